// File: rtl/spi_pkg.sv
// Shared state encoding, parameter limits and clock-edge helpers for the 3-wire SPI slave.
package spi_pkg;

    typedef enum logic [2:0] {
        StWaitCs,
        StIdle,
        StRx,
        StTurn,
        StTx,
        StDone
    } spi_state_e;

    localparam int unsigned DataWMin = 4;
    localparam int unsigned DataWMax = 32;
    localparam int unsigned TurnMax  = 7;

    // CPHA is fixed at 0: the leading edge samples, the trailing edge shifts.
    function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

    function automatic logic trail_edge(input logic cpol, input logic rise, input logic fall);
        return cpol ? rise : fall;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-clk rise/fall pulses taken
// from the synchronised level against a one-clk delayed copy.
module spi_sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {3{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_half_duplex_os.sv
// Oversampled half-duplex SPI slave: master word, turnaround, then an optional response word.
// Define SPI_SLAVE_PARITY_EN to append an even-parity bit to both directions.
module spi_slave_half_duplex_os
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TURN_CYCLES = 1,
    parameter logic        CPOL        = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_io_in,
    output logic              spi_io_out,
    output logic              spi_io_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              frame_err
);

`ifdef SPI_SLAVE_PARITY_EN
    localparam int unsigned ParW = 1;
`else
    localparam int unsigned ParW = 0;
`endif
    localparam int unsigned RxW      = DATA_W + ParW;
    localparam logic [5:0]  BitLast  = 6'(RxW - 1);
    localparam logic [2:0]  TurnLast = 3'(TURN_CYCLES);

    if (DATA_W < DataWMin || DATA_W > DataWMax || TURN_CYCLES > TurnMax) begin : gen_param_err
        $error("spi_slave_half_duplex_os: DATA_W or TURN_CYCLES out of range");
    end

    logic sclk_rise, sclk_fall, sclk_level;
    logic cs_rise, cs_fall, cs_level;
    logic io_level, io_rise, io_fall;
    logic unused_edges;

    // cs resets low so a frame already in progress is not mistaken for a fresh one.
    spi_sync_edge #(.ResetVal(CPOL)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_sclk),
        .level_o(sclk_level),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.ResetVal(1'b0)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_cs),
        .level_o(cs_level),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.ResetVal(1'b0)) u_sync_io (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi_io_in),
        .level_o(io_level),
        .rise_o (io_rise),
        .fall_o (io_fall)
    );

    assign unused_edges = ^{io_rise, io_fall, sclk_level};

    logic sclk_lead, sclk_trail;
    assign sclk_lead  = lead_edge(CPOL, sclk_rise, sclk_fall);
    assign sclk_trail = trail_edge(CPOL, sclk_rise, sclk_fall);

    spi_state_e         state_q, state_d;
    logic [5:0]         bitcnt_q, bitcnt_d;
    logic [2:0]         turn_cnt_q, turn_cnt_d;
    logic [RxW-1:0]     rx_shift_q, rx_shift_d;
    logic [RxW-1:0]     tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_load_q, tx_load_d;
    logic               oe_q, oe_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;

    logic [RxW-1:0]     rx_shift_nx;
    logic [DATA_W-1:0]  rx_word;
    logic [RxW-1:0]     tx_load_word;
    logic               parity_err;

    assign rx_shift_nx = {rx_shift_q[RxW-2:0], io_level};
    assign rx_word     = rx_shift_nx[RxW-1 -: DATA_W];

`ifdef SPI_SLAVE_PARITY_EN
    assign tx_load_word = {tx_data, ^tx_data};
    assign parity_err   = ^rx_shift_nx;
`else
    assign tx_load_word = tx_data;
    assign parity_err   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        turn_cnt_d  = turn_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        oe_d        = oe_q;
        out_d       = out_q;
        busy_d      = busy_q;
        frame_err_d = 1'b0;

        // Response word is sampled in the clk after rx_valid.
        if (tx_load_q) begin
            tx_shift_d = tx_load_word;
        end

        unique case (state_q)
            StWaitCs: begin
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (cs_level) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (cs_fall) begin
                    state_d  = StRx;
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                end
            end
            StRx: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    oe_d        = 1'b0;
                    frame_err_d = (bitcnt_q != '0);
                end else if (sclk_lead) begin
                    rx_shift_d = rx_shift_nx;
                    bitcnt_d   = bitcnt_q + 6'd1;
                    if (bitcnt_q == BitLast) begin
                        turn_cnt_d = '0;
                        if (parity_err) begin
                            frame_err_d = 1'b1;
                            state_d     = StDone;
                        end else begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                            tx_load_d  = rx_word[DATA_W-1];
                            state_d    = rx_word[DATA_W-1] ? StTurn : StDone;
                        end
                    end
                end
            end
            StTurn: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    oe_d        = 1'b0;
                    frame_err_d = 1'b1;
                end else if (turn_cnt_q == TurnLast) begin
                    if (sclk_trail) begin
                        state_d  = StTx;
                        bitcnt_d = '0;
                        oe_d     = 1'b1;
                        out_d    = tx_shift_q[RxW-1];
                    end
                end else if (sclk_lead) begin
                    turn_cnt_d = turn_cnt_q + 3'd1;
                end
            end
            StTx: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    oe_d        = 1'b0;
                    out_d       = 1'b0;
                    frame_err_d = 1'b1;
                end else if (sclk_trail) begin
                    tx_shift_d = {tx_shift_q[RxW-2:0], 1'b0};
                    out_d      = tx_shift_q[RxW-2];
                end else if (sclk_lead) begin
                    bitcnt_d = bitcnt_q + 6'd1;
                    if (bitcnt_q == BitLast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // The last response bit stays on the pad until the master's trailing edge.
                if (cs_rise) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    out_d   = 1'b0;
                end else if (sclk_trail) begin
                    oe_d  = 1'b0;
                    out_d = 1'b0;
                end
            end
            default: begin
                state_d = StWaitCs;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitCs;
            bitcnt_q    <= '0;
            turn_cnt_q  <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            oe_q        <= 1'b0;
            out_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            turn_cnt_q  <= turn_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_io_out = out_q;
    assign spi_io_oe  = oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_half_duplex_os.sv
// Bench for spi_slave_half_duplex_os: a bit-banged SPI master drives two instances
// (16-bit/CPOL0/turn 1 and 8-bit/CPOL1/turn 0) and frame outcomes are predicted per frame.
module tb_spi_slave_half_duplex_os;

    localparam int H = 50;  // half sclk period in ns (clk period 10 ns)
`ifdef SPI_SLAVE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs_a = 1'b1;
    logic cs_b = 1'b1;
    logic [15:0] tx_a = '0;
    logic [7:0]  tx_b = '0;

    logic        out_a, oe_a, rxv_a, busy_a, ferr_a, io_a;
    logic [15:0] rxd_a;
    logic        out_b, oe_b, rxv_b, busy_b, ferr_b, io_b;
    logic [7:0]  rxd_b;

    always #5 clk = ~clk;

    // Pad model: slave wins the wire whenever it enables its driver.
    assign io_a = oe_a ? out_a : mosi;
    assign io_b = oe_b ? out_b : mosi;

    spi_slave_half_duplex_os #(.DATA_W(16), .TURN_CYCLES(1), .CPOL(1'b0)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (sclk),
        .spi_cs    (cs_a),
        .spi_io_in (io_a),
        .spi_io_out(out_a),
        .spi_io_oe (oe_a),
        .rx_data   (rxd_a),
        .rx_valid  (rxv_a),
        .tx_data   (tx_a),
        .busy      (busy_a),
        .frame_err (ferr_a)
    );

    spi_slave_half_duplex_os #(.DATA_W(8), .TURN_CYCLES(0), .CPOL(1'b1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (sclk),
        .spi_cs    (cs_b),
        .spi_io_in (io_b),
        .spi_io_out(out_b),
        .spi_io_oe (oe_b),
        .rx_data   (rxd_b),
        .rx_valid  (rxv_b),
        .tx_data   (tx_b),
        .busy      (busy_b),
        .frame_err (ferr_b)
    );

    int cur = 0;
    logic cur_oe, cur_busy, pad_cur;
    assign cur_oe   = (cur == 1) ? oe_b : oe_a;
    assign cur_busy = (cur == 1) ? busy_b : busy_a;
    assign pad_cur  = (cur == 1) ? io_b : io_a;

    int          nvalid[2] = '{0, 0};
    int          nerr[2]   = '{0, 0};
    logic [31:0] last_rx[2];
    int          oe_viol = 0;
    bit          oe_forbid = 1'b0;

    always @(negedge clk) begin
        if (rxv_a) begin
            nvalid[0]  = nvalid[0] + 1;
            last_rx[0] = 32'(rxd_a);
        end
        if (rxv_b) begin
            nvalid[1]  = nvalid[1] + 1;
            last_rx[1] = 32'(rxd_b);
        end
        if (ferr_a) nerr[0] = nerr[0] + 1;
        if (ferr_b) nerr[1] = nerr[1] + 1;
        if (oe_forbid && cur_oe) oe_viol = oe_viol + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dw_of(input int s);
        return (s == 1) ? 8 : 16;
    endfunction

    function automatic int turn_of(input int s);
        return (s == 1) ? 0 : 1;
    endfunction

    function automatic logic [31:0] mask_of(input int s);
        return (s == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    endfunction

    // Leading edges in a complete frame: word (+parity), turnaround and response for reads.
    function automatic int frame_len(input int s, input logic [31:0] word, input bit bad_par);
        int rxb;
        rxb = dw_of(s) + PAR;
        if (word[dw_of(s)-1] && !bad_par) return rxb + turn_of(s) + dw_of(s) + PAR;
        return rxb;
    endfunction

    logic [31:0] miso_w;
    int          oe_miss, dv, de;
    logic        busy_mid, busy_end, oe_after;

    // Master: drive data before each leading edge, sample the pad on leading edges.
    // limit = number of leading edges to issue before raising cs.
    task automatic run_frame(input int s, input logic [31:0] word, input logic [31:0] txw,
                             input bit bad_par, input int limit, input int rst_at);
        int dw, rxb, turn, v0, e0;
        bit cpol, rd;
        logic [32:0] bits;
        dw   = dw_of(s);
        turn = turn_of(s);
        cpol = (s == 1);
        rxb  = dw + PAR;
        rd   = word[dw-1] && !bad_par;
        bits = '0;
        for (int i = 0; i < dw; i++) bits[rxb-1-i] = word[dw-1-i];
        if (PAR == 1) bits[0] = (^(word & mask_of(s))) ^ bad_par;

        cur  = s;
        tx_a = txw[15:0];
        tx_b = txw[7:0];
        sclk = cpol;
        mosi = bits[rxb-1];
        repeat (4) @(negedge clk);
        v0 = nvalid[s];
        e0 = nerr[s];
        oe_viol   = 0;
        oe_miss   = 0;
        miso_w    = '0;
        busy_mid  = 1'b0;
        oe_forbid = 1'b1;
        if (s == 0) cs_a = 1'b0; else cs_b = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (k < rxb) mosi = bits[rxb-1-k];
            #H;
            sclk = ~cpol;
            if (k == 0) busy_mid = cur_busy;
            if (k >= rxb + turn) begin
                miso_w = {miso_w[30:0], pad_cur};
                if (!cur_oe) oe_miss++;
            end
            #H;
            sclk = cpol;
            if (rd && k == rxb + turn - 1) oe_forbid = 1'b0;
            if (k == rst_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_val("oe_clk_after_rst", 32'(cur_oe), 32'd0);
                oe_forbid = 1'b1;
            end
        end
        #H;
        oe_after = cur_oe;
        if (s == 0) cs_a = 1'b1; else cs_b = 1'b1;
        oe_forbid = 1'b0;
        #H;
        busy_end = cur_busy;
        dv = nvalid[s] - v0;
        de = nerr[s] - e0;
    endtask

    task automatic frame_check(input int s, input logic [31:0] word, input logic [31:0] txw,
                               input bit bad_par, input int limit);
        int dw, rxb, full;
        bit rd, got, exp_valid, exp_err;
        logic [31:0] mask, exp_resp;
        run_frame(s, word, txw, bad_par, limit, -1);
        dw   = dw_of(s);
        rxb  = dw + PAR;
        mask = mask_of(s);
        full = frame_len(s, word, bad_par);
        rd   = word[dw-1];
        got       = (limit >= rxb);
        exp_valid = got && !bad_par;
        exp_err   = (limit > 0 && limit < rxb) || (got && bad_par) ||
                    (exp_valid && rd && limit < full);
        check_val("rx_valid_count", 32'(dv), 32'(exp_valid));
        check_val("frame_err_count", 32'(de), 32'(exp_err));
        if (exp_valid) check_val("rx_data", last_rx[s], word & mask);
        if (exp_valid && rd && limit == full) begin
            exp_resp = txw & mask;
            if (PAR == 1) exp_resp = {exp_resp[30:0], ^(txw & mask)};
            check_val("miso_word", miso_w, exp_resp);
            check_val("oe_after_last_trail", 32'(oe_after), 32'd0);
        end
        check_val("oe_low_rx_turn", 32'(oe_viol), 32'd0);
        check_val("oe_high_at_sample", 32'(oe_miss), 32'd0);
        if (limit > 0) check_val("busy_in_frame", 32'(busy_mid), 32'd1);
        check_val("busy_after_cs", 32'(busy_end), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, full, limit;
        bit bad;
        logic [31:0] word, txw;

        repeat (5) @(negedge clk);
        check_val("rst_rx_data", 32'(rxd_a), 32'd0);
        check_val("rst_rx_valid", 32'(rxv_a), 32'd0);
        check_val("rst_oe", 32'(oe_a), 32'd0);
        check_val("rst_out", 32'(out_a), 32'd0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_frame_err", 32'(ferr_a), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        frame_check(0, 32'h3A5C, 32'h0000, 1'b0, frame_len(0, 32'h3A5C, 1'b0));
        frame_check(0, 32'h8001, 32'hCC33, 1'b0, frame_len(0, 32'h8001, 1'b0));
        frame_check(0, 32'h1234, 32'h0000, 1'b0, 5);
        frame_check(0, 32'h1234, 32'h0000, 1'b0, frame_len(0, 32'h1234, 1'b0));

        // Reset in the middle of the response: pad released, rest of frame ignored.
        run_frame(0, 32'h8001, 32'hCC33, 1'b0, frame_len(0, 32'h8001, 1'b0), 16 + PAR + 1 + 4);
        check_val("rst_mid_tx_valid", 32'(dv), 32'd1);
        check_val("rst_mid_tx_err", 32'(de), 32'd0);
        check_val("rst_mid_tx_rx_data", 32'(rxd_a), 32'd0);
        check_val("rst_mid_tx_oe", 32'(oe_viol), 32'd0);
        check_val("rst_mid_tx_busy", 32'(busy_end), 32'd0);
        frame_check(0, 32'h80F0, 32'h5A5A, 1'b0, frame_len(0, 32'h80F0, 1'b0));

        frame_check(1, 32'h81, 32'hA5, 1'b0, frame_len(1, 32'h81, 1'b0));
        frame_check(1, 32'h12, 32'h00, 1'b0, frame_len(1, 32'h12, 1'b0));
`ifdef SPI_SLAVE_PARITY_EN
        frame_check(0, 32'h8001, 32'hCC33, 1'b1, frame_len(0, 32'h8001, 1'b1));
`endif

        for (int n = 0; n < 40; n++) begin
            s     = (n % 4 == 3) ? 1 : 0;
            word  = $urandom & mask_of(s);
            txw   = $urandom & mask_of(s);
            bad   = (PAR == 1) && ($urandom_range(0, 7) == 0);
            full  = frame_len(s, word, bad);
            limit = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, full - 1)) : full;
            frame_check(s, word, txw, bad, limit);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
